// File: rtl/i_adap_quan_pkg.sv
// Shared types, rate encodings and DQLN reconstruction tables for the
// pipelined inverse adaptive quantizer.
package i_adap_quan_pkg;

   localparam logic [1:0] RATE_32K = 2'b00;
   localparam logic [1:0] RATE_24K = 2'b01;
   localparam logic [1:0] RATE_16K = 2'b10;
   localparam logic [1:0] RATE_40K = 2'b11;

   typedef logic [11:0] dql_t;
   typedef logic [15:0] d_t;

   typedef struct packed {
      logic dqs;
      dql_t dqln;
   } recon_t;

   // Indexed by magnitude code; 2048 sets DS and forces a zero magnitude.
   localparam dql_t DQLN_40K [16] = '{
      12'd2048, 12'd4030, 12'd28,  12'd104, 12'd169, 12'd224, 12'd274, 12'd318,
      12'd358,  12'd395,  12'd429, 12'd459, 12'd488, 12'd514, 12'd539, 12'd566};
   localparam dql_t DQLN_32K [8] = '{
      12'd2048, 12'd4, 12'd135, 12'd213, 12'd273, 12'd323, 12'd373, 12'd425};
   localparam dql_t DQLN_24K [4] = '{12'd2048, 12'd135, 12'd273, 12'd373};
   localparam dql_t DQLN_16K [2] = '{12'd116, 12'd365};

   // Negative codewords are one's-complemented to reach the magnitude index.
   function automatic recon_t reconstruct(input logic [1:0] rate, input logic [4:0] code);
      recon_t     r;
      logic [3:0] mag;
      r   = '0;
      mag = '0;
      case (rate)
         RATE_40K: begin
            r.dqs  = code[4];
            mag    = code[4] ? ~code[3:0] : code[3:0];
            r.dqln = DQLN_40K[mag];
         end
         RATE_32K: begin
            r.dqs    = code[3];
            mag[2:0] = code[3] ? ~code[2:0] : code[2:0];
            r.dqln   = DQLN_32K[mag[2:0]];
         end
         RATE_24K: begin
            r.dqs    = code[2];
            mag[1:0] = code[2] ? ~code[1:0] : code[1:0];
            r.dqln   = DQLN_24K[mag[1:0]];
         end
         default: begin
            r.dqs  = code[1];
            mag[0] = code[1] ? ~code[0] : code[0];
            r.dqln = DQLN_16K[mag[0]];
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/i_adap_quan_antilog.sv
// Combinational log-to-linear conversion: {DQS, DQL} -> 16-bit sign-magnitude D.
module i_adap_quan_antilog
   import i_adap_quan_pkg::*;
(
   input  dql_t dql_i,
   input  logic dqs_i,
   output d_t   d_o
);

   logic        ds;
   logic [3:0]  dex;
   logic [6:0]  dmn;
   logic [15:0] wide;
   logic [3:0]  sh;
   logic [14:0] mag_raw;

   assign ds  = dql_i[11];
   assign dex = dql_i[10:7];
   assign dmn = dql_i[6:0];

   // {DQT,8'b0} >> (15-DEX) equals (DQT<<7)>>(14-DEX), and also covers DEX=15
   // as a one-bit left shift that is then truncated to 15 bits.
   assign wide    = {1'b1, dmn, 8'b0};
   assign sh      = 4'd15 - dex;
   assign mag_raw = 15'(wide >> sh);

   assign d_o = {dqs_i, (ds ? 15'd0 : mag_raw)};

endmodule

// File: rtl/i_adap_quan_pipe.sv
// Pipelined multi-channel inverse adaptive quantizer with valid/ready stalls.
// Define I_ADAP_QUAN_PIPE_OREG_EN to add a registered output stage (S3).
module i_adap_quan_pipe
   import i_adap_quan_pkg::*;
#(
   parameter int NCH = 32,
   parameter int CHW = $clog2(NCH)
)(
   input  logic           clk_i,
   input  logic           rst_n_i,
   input  logic           in_valid_i,
   output logic           in_ready_o,
   input  logic [4:0]     i_i,
   input  logic [12:0]    y_i,
   input  logic [1:0]     rate_i,
   input  logic [CHW-1:0] ch_i,
   output logic           out_valid_o,
   input  logic           out_ready_i,
   output logic [15:0]    d_o,
   output logic [CHW-1:0] ch_out_o,
   output logic           err_o
);

   localparam logic [CHW:0] NCH_W = (CHW+1)'(NCH);

   recon_t         recon;
   dql_t           dql_in;
   logic           ch_legal;
   logic           accept;
   logic           s1_load;
   logic           s2_load;
   d_t             antilog_d;
   logic           unused_y;

   logic           s1_valid_q, s1_valid_d;
   logic           s1_dqs_q,   s1_dqs_d;
   dql_t           s1_dql_q,   s1_dql_d;
   logic [CHW-1:0] s1_ch_q,    s1_ch_d;
   logic           s2_valid_q, s2_valid_d;
   d_t             s2_d_q,     s2_d_d;
   logic [CHW-1:0] s2_ch_q,    s2_ch_d;
   logic           err_q,      err_d;

   assign unused_y = ^y_i[1:0];

   always_comb begin
      recon  = reconstruct(rate_i, i_i);
      dql_in = recon.dqln + dql_t'(y_i[12:2]);
   end

   assign ch_legal = ({1'b0, ch_i} < NCH_W);

`ifdef I_ADAP_QUAN_PIPE_OREG_EN
   logic           s3_load;
   logic           s3_valid_q, s3_valid_d;
   d_t             s3_d_q,     s3_d_d;
   logic [CHW-1:0] s3_ch_q,    s3_ch_d;

   assign s3_load = !s3_valid_q | out_ready_i;
   assign s2_load = !s2_valid_q | s3_load;

   always_comb begin
      s3_valid_d = s3_valid_q;
      s3_d_d     = s3_d_q;
      s3_ch_d    = s3_ch_q;
      if (s3_load) begin
         s3_valid_d = s2_valid_q;
         if (s2_valid_q) begin
            s3_d_d  = s2_d_q;
            s3_ch_d = s2_ch_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s3_valid_q <= 1'b0;
         s3_d_q     <= '0;
         s3_ch_q    <= '0;
      end else begin
         s3_valid_q <= s3_valid_d;
         s3_d_q     <= s3_d_d;
         s3_ch_q    <= s3_ch_d;
      end
   end

   assign out_valid_o = s3_valid_q;
   assign d_o         = s3_d_q;
   assign ch_out_o    = s3_ch_q;
`else
   assign s2_load     = !s2_valid_q | out_ready_i;
   assign out_valid_o = s2_valid_q;
   assign d_o         = s2_d_q;
   assign ch_out_o    = s2_ch_q;
`endif

   // Each stage loads when empty or draining, so bubbles collapse.
   assign s1_load    = !s1_valid_q | s2_load;
   assign in_ready_o = s1_load;
   assign accept     = in_valid_i & s1_load;

   i_adap_quan_antilog u_antilog (
      .dql_i (s1_dql_q),
      .dqs_i (s1_dqs_q),
      .d_o   (antilog_d)
   );

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_dqs_d   = s1_dqs_q;
      s1_dql_d   = s1_dql_q;
      s1_ch_d    = s1_ch_q;
      s2_valid_d = s2_valid_q;
      s2_d_d     = s2_d_q;
      s2_ch_d    = s2_ch_q;
      err_d      = err_q | (accept & !ch_legal);

      // Out-of-range tags are accepted but never marked valid.
      if (s1_load) begin
         s1_valid_d = accept & ch_legal;
      end
      if (accept & ch_legal) begin
         s1_dqs_d = recon.dqs;
         s1_dql_d = dql_in;
         s1_ch_d  = ch_i;
      end

      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_d_d  = antilog_d;
            s2_ch_d = s1_ch_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_valid_q <= 1'b0;
         s1_dqs_q   <= 1'b0;
         s1_dql_q   <= '0;
         s1_ch_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_d_q     <= '0;
         s2_ch_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_dqs_q   <= s1_dqs_d;
         s1_dql_q   <= s1_dql_d;
         s1_ch_q    <= s1_ch_d;
         s2_valid_q <= s2_valid_d;
         s2_d_q     <= s2_d_d;
         s2_ch_q    <= s2_ch_d;
         err_q      <= err_d;
      end
   end

   assign err_o = err_q;

endmodule

// File: tb/tb_i_adap_quan_pipe.sv
// Directed self-checking bench for i_adap_quan_pipe (NCH=32 and NCH=40 instances).
module tb_i_adap_quan_pipe;

`ifdef I_ADAP_QUAN_PIPE_OREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int NSTG = LAT + 1;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  i_code;
   logic [12:0] y;
   logic [1:0]  rate;
   logic [4:0]  ch;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] d;
   logic [4:0]  ch_out;
   logic        err;

   logic        in_valid40;
   logic        in_ready40;
   logic [5:0]  ch40;
   logic        out_valid40;
   logic        out_ready40;
   logic [15:0] d40;
   logic [5:0]  ch_out40;
   logic        err40;

   int checks;
   int failures;

   typedef struct {
      logic [4:0]  code;
      logic [12:0] yy;
      logic [1:0]  r;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs [10];

   i_adap_quan_pipe #(.NCH(32)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .i_i(i_code), .y_i(y), .rate_i(rate), .ch_i(ch),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .d_o(d), .ch_out_o(ch_out), .err_o(err)
   );

   i_adap_quan_pipe #(.NCH(40)) dut40 (
      .clk_i(clk), .rst_n_i(rst_n),
      .in_valid_i(in_valid40), .in_ready_o(in_ready40),
      .i_i(i_code), .y_i(y), .rate_i(rate), .ch_i(ch40),
      .out_valid_o(out_valid40), .out_ready_i(out_ready40),
      .d_o(d40), .ch_out_o(ch_out40), .err_o(err40)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one sample on the NCH=32 instance and reports edges until OUT_VALID (-1 on timeout).
   task automatic send_one(input logic [4:0] c, input logic [12:0] yy, input logic [1:0] r,
                           input logic [4:0] chh, output int lat);
      i_code = c; y = yy; rate = r; ch = chh;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      in_valid = 1'b0; in_valid40 = 1'b0; out_ready = 1'b1; out_ready40 = 1'b1;
      i_code = '0; y = '0; rate = 2'b00; ch = '0; ch40 = '0;
      #1 rst_n = 1'b0;
      #2;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (d !== 16'h0000) begin failures++; $display("FAIL reset_d: got %h expected 0000", d); end
      checks++; if (ch_out !== 5'd0) begin failures++; $display("FAIL reset_ch_out: got %0d expected 0", ch_out); end
      checks++; if (err !== 1'b0 || err40 !== 1'b0) begin failures++; $display("FAIL reset_err: got %b/%b expected 0/0", err, err40); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1 || in_ready40 !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b/%b expected 1/1", in_ready, in_ready40); end
   endtask

   task automatic test_single();
      int lat;
      send_one(5'b00001, 13'd0, 2'b00, 5'd3, lat);
      checks++; if (lat !== LAT) begin failures++; $display("FAIL single_latency: got %0d expected %0d", lat, LAT); end
      checks++; if (d !== 16'h0001) begin failures++; $display("FAIL single_d: got %h expected 0001", d); end
      checks++; if (ch_out !== 5'd3) begin failures++; $display("FAIL single_ch_out: got %0d expected 3", ch_out); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drained: got %b expected 0", out_valid); end
   endtask

   task automatic test_scale_vectors();
      int lat;
      for (int k = 0; k < 10; k++) begin
         send_one(vecs[k].code, vecs[k].yy, vecs[k].r, 5'(k + 4), lat);
         checks++;
         if (lat !== LAT) begin failures++; $display("FAIL vec%0d_latency: got %0d expected %0d", k, lat, LAT); end
         checks++;
         if (d !== vecs[k].exp || ch_out !== 5'(k + 4))
            begin failures++; $display("FAIL vec%0d_d: got %h ch %0d expected %h ch %0d", k, d, ch_out, vecs[k].exp, k + 4); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int tx, rx, occ;
      logic prev_stall, exp_rdy, acc, emit;
      logic [15:0] prev_d;
      logic [4:0]  prev_ch;
      tx = 0; rx = 0; occ = 0; prev_stall = 1'b0; prev_d = '0; prev_ch = '0;
      for (int cyc = 0; cyc < 300 && rx < 8; cyc++) begin
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || d !== prev_d || ch_out !== prev_ch)
               begin failures++; $display("FAIL stall_hold: got v=%b d=%h ch=%0d expected v=1 d=%h ch=%0d", out_valid, d, ch_out, prev_d, prev_ch); end
         end
         out_ready = (cyc < 3) ? 1'b0 : 1'($urandom_range(0, 1));
         if (tx < 8) begin
            in_valid = 1'b1;
            i_code = vecs[tx].code; y = vecs[tx].yy; rate = vecs[tx].r; ch = 5'(tx % 2);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         exp_rdy = !(occ == NSTG && !out_ready);
         checks++;
         if (in_ready !== exp_rdy) begin failures++; $display("FAIL bp_in_ready: got %b expected %b (occ %0d)", in_ready, exp_rdy, occ); end
         acc  = in_valid && in_ready;
         emit = out_valid && out_ready;
         if (emit) begin
            checks++;
            if (rx >= 8) begin
               failures++; $display("FAIL bp_extra_output: got d=%h expected none", d);
            end else if (d !== vecs[rx].exp || ch_out !== 5'(rx % 2)) begin
               failures++; $display("FAIL bp_order%0d: got d=%h ch=%0d expected d=%h ch=%0d", rx, d, ch_out, vecs[rx].exp, rx % 2);
            end
            rx++;
         end
         prev_stall = out_valid && !out_ready;
         prev_d = d; prev_ch = ch_out;
         occ = occ + int'(acc) - int'(emit);
         tx = tx + int'(acc);
         @(posedge clk); #1;
      end
      checks++; if (rx !== 8) begin failures++; $display("FAIL bp_count: got %0d expected 8", rx); end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup: got %b expected 0", out_valid); end
   endtask

   task automatic test_illegal_channel();
      int lat;
      logic saw;
      send_one(5'b00001, 13'd0, 2'b00, 5'd31, lat);
      checks++;
      if (lat !== LAT || ch_out !== 5'd31 || d !== 16'h0001)
         begin failures++; $display("FAIL ch31_legal: got lat=%0d ch=%0d d=%h expected lat=%0d ch=31 d=0001", lat, ch_out, d, LAT); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL ch31_err: got %b expected 0", err); end
      @(posedge clk); #1;

      checks++; if (err40 !== 1'b0) begin failures++; $display("FAIL ch45_err_before: got %b expected 0", err40); end
      i_code = 5'b00001; y = 13'd0; rate = 2'b00; ch40 = 6'd45; in_valid40 = 1'b1;
      @(posedge clk); #1;
      in_valid40 = 1'b0;
      checks++; if (err40 !== 1'b1) begin failures++; $display("FAIL ch45_err_next: got %b expected 1", err40); end
      saw = 1'b0;
      for (int n = 0; n < LAT + 3; n++) begin
         if (out_valid40) saw = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (saw !== 1'b0) begin failures++; $display("FAIL ch45_dropped: got out_valid=%b expected 0", saw); end

      i_code = 5'b01111; y = 13'd0; rate = 2'b11; ch40 = 6'd39; in_valid40 = 1'b1;
      @(posedge clk); #1;
      in_valid40 = 1'b0;
      lat = 0;
      while (!out_valid40 && lat < 8) begin @(posedge clk); #1; lat++; end
      checks++;
      if (out_valid40 !== 1'b1 || ch_out40 !== 6'd39 || d40 !== 16'h0016)
         begin failures++; $display("FAIL ch39_legal: got v=%b ch=%0d d=%h expected v=1 ch=39 d=0016", out_valid40, ch_out40, d40); end
      @(posedge clk); #1;
      checks++; if (err40 !== 1'b1) begin failures++; $display("FAIL ch45_err_sticky: got %b expected 1", err40); end
   endtask

   task automatic test_midstall_reset();
      int acc_cnt;
      logic saw;
      acc_cnt = 0;
      out_ready = 1'b0;
      for (int n = 0; n < 10; n++) begin
         in_valid = 1'b1;
         i_code = vecs[n % 10].code; y = vecs[n % 10].yy; rate = vecs[n % 10].r; ch = 5'(n);
         #1;
         if (!in_ready) break;
         @(posedge clk); #1;
         acc_cnt++;
      end
      checks++; if (acc_cnt !== NSTG) begin failures++; $display("FAIL full_count: got %0d expected %0d", acc_cnt, NSTG); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL full_out_valid: got %b expected 1", out_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      checks++; if (d !== 16'h0000 || ch_out !== 5'd0) begin failures++; $display("FAIL rst_data: got d=%h ch=%0d expected 0000/0", d, ch_out); end
      checks++; if (err40 !== 1'b0) begin failures++; $display("FAIL rst_err_clear: got %b expected 0", err40); end
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      saw = 1'b0;
      for (int n = 0; n < 5; n++) begin
         @(posedge clk); #1;
         if (out_valid) saw = 1'b1;
      end
      checks++; if (saw !== 1'b0) begin failures++; $display("FAIL rst_nothing_emitted: got %b expected 0", saw); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      vecs[0] = '{5'b00001, 13'd544,  2'b00, 16'h0002};
      vecs[1] = '{5'b00000, 13'd544,  2'b00, 16'h0000};
      vecs[2] = '{5'b00001, 13'd544,  2'b11, 16'h0001};
      vecs[3] = '{5'b00001, 13'd0,    2'b11, 16'h0000};
      vecs[4] = '{5'b00010, 13'd0,    2'b10, 16'h8007};
      vecs[5] = '{5'b00011, 13'd4000, 2'b01, 16'h06E8};
      vecs[6] = '{5'b00111, 13'd6400, 2'b00, 16'h6900};
      vecs[7] = '{5'b00111, 13'd5600, 2'b00, 16'h5080};
      vecs[8] = '{5'b01110, 13'd0,    2'b00, 16'h8001};
      vecs[9] = '{5'b01111, 13'd0,    2'b11, 16'h0016};
      test_reset();
      test_single();
      test_scale_vectors();
      test_back_to_back();
      test_illegal_channel();
      test_midstall_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
